morse_src_arbiter: RTL and testbench
====================================

MORSE_SRC_ARBITER -- requirements
Module: morse_src_arbiter

Interface
REQ-001 Parameter N, default 3: symbol code width in bits.
REQ-002 Parameter HOLD, default 4: cycles each granted symbol stays on the output (HOLD >= 1).
REQ-003 Parameter GAP, default 2: idle cycles after each symbol before the next grant (GAP >= 1).
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0  input  1  source 0 requests the channel; held high until gnt0.
REQ-007 sym0  input  N  source 0 symbol code; stable while req0 is high.
REQ-008 req1  input  1  source 1 request; same rules as req0.
REQ-009 sym1  input  N  source 1 symbol code; same rules as sym0.
REQ-010 gnt0  output  1  one-cycle pulse: sym0 has been captured.
REQ-011 gnt1  output  1  one-cycle pulse: sym1 has been captured.
REQ-012 sel  output  1  shared 2:1 mux select, registered; 1 = source 0 (w0), 0 = source 1 (w1).
REQ-013 sym_out  output  N  registered symbol presented to the transmit path.
REQ-014 out_valid  output  1  high while sym_out holds a granted symbol.
REQ-015 busy  output  1  high in HOLD and GAP states.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, HOLD and GAP.
REQ-017 IDLE behaviour: if req0 or req1 is high at a clock edge, the block SHALL pick a winner, enter HOLD, and load cnt = HOLD-1.
- In that same edge it SHALL register sym_out, set sel, and set out_valid=1.
- The winner's gnt SHALL be high for exactly the first HOLD cycle.
REQ-018 Single request: that source SHALL win.
REQ-019 Simultaneous requests: the source not granted most recently SHALL win (round-robin).
- The last-granted flag resets to "source 1", so source 0 wins the first tie.
REQ-020 Latency: req sampled high in IDLE at edge t means gnt, out_valid and sym_out are all valid in the cycle after edge t. There SHALL be no combinational path from req to gnt.
REQ-021 HOLD behaviour: sym_out, sel and out_valid SHALL stay constant for exactly HOLD cycles.
- cnt decrements each cycle.
- At cnt==0 the FSM SHALL enter GAP with cnt = GAP-1 and out_valid=0.
REQ-022 GAP behaviour: out_valid=0 and sel holds its value; at cnt==0 the FSM SHALL return to IDLE.
- A symbol therefore occupies HOLD+GAP cycles, and the next grant can occur no earlier than HOLD+GAP+1 cycles after the previous one.
REQ-023 Requests during HOLD or GAP SHALL be ignored, with no grant and no capture; they are arbitrated on the first IDLE edge.
REQ-024 A request deasserted before its grant SHALL never be granted, and sym_out SHALL be unaffected.
REQ-025 gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-026 Changes to sym0/sym1 after capture SHALL NOT alter sym_out.
REQ-027 The counter SHALL be wide enough for max(HOLD,GAP)-1 and SHALL never wrap below zero.
REQ-028 busy SHALL be 1 exactly when state is HOLD or GAP.

Reset
REQ-029 On reset=1 at a clock edge, from any state (including mid-HOLD or mid-GAP), the block SHALL reach IDLE on that edge with:
- sym_out=0, sel=0, out_valid=0, gnt0=gnt1=0, busy=0, cnt=0;
- last-granted flag = source 1.
REQ-030 While reset is high, requests SHALL be ignored.
REQ-031 The first arbitration SHALL occur on the first edge where reset is low.

Verification
REQ-032 N=3, HOLD=4, GAP=2. Scenario: req0=1, sym0=3'b101 in IDLE.
- Next cycle: gnt0=1, sel=1, sym_out=101, out_valid=1.
- out_valid stays 1 for 4 cycles, is 0 for 2 cycles, then the block is back in IDLE.
REQ-033 Scenario: req0 and req1 both high after reset, held until granted, sym0=001, sym1=110.
- Grants in order: gnt0 (sym_out=001), then gnt1 (sym_out=110, sel=0).
- The two grants are exactly 7 cycles apart.
REQ-034 Scenario: req1 held continuously with sym1 changed during HOLD.
- sym_out stays at the captured value.
- The next gnt1 occurs only after GAP expires.
REQ-035 Scenario: reset asserted on the 2nd HOLD cycle.
- Next cycle: all outputs 0, state IDLE.
- With both requests high afterwards, source 0 is granted first.
REQ-036 Scenario: req0 pulsed high for one cycle during GAP, then low.
- No gnt0 ever occurs, and out_valid stays 0.
REQ-037 Scenario: random req0/req1/sym stimulus, checked against a reference model. Every cycle:
- gnt0 and gnt1 are never both high;
- out_valid run length = HOLD and gap length = GAP;
- sym_out equals the symbol presented by the granted source in its grant cycle.

Source files
------------

// File: rtl/morse_src_arbiter.sv
// Two-source round-robin arbiter feeding a shared Morse symbol transmit path.
// Each granted symbol is held for HOLD cycles, followed by GAP idle cycles.
module morse_src_arbiter #(
  parameter int unsigned N    = 3,
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [N-1:0] sym0,
  input  logic         req1,
  input  logic [N-1:0] sym1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sel,
  output logic [N-1:0] sym_out,
  output logic         out_valid,
  output logic         busy
);

  localparam int unsigned MAXC = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_is_1;
  logic          pick1;

  // Source 1 wins when it is the only requester, or on a tie when source 0 was served last.
  always_comb begin
    pick1 = req1 && (!req0 || !last_is_1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sym_out   <= '0;
      sel       <= 1'b0;
      out_valid <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      busy      <= 1'b0;
      last_is_1 <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
          if (req0 || req1) begin
            state     <= ST_HOLD;
            cnt       <= HOLD_LOAD;
            sym_out   <= pick1 ? sym1 : sym0;
            sel       <= !pick1;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            gnt0      <= !pick1;
            gnt1      <= pick1;
            last_is_1 <= pick1;
          end
        end
        ST_HOLD: begin
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
          if (cnt == '0) begin
            state     <= ST_GAP;
            cnt       <= GAP_LOAD;
            out_valid <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          out_valid <= 1'b0;
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_src_arbiter.sv
// Scoreboard bench for morse_src_arbiter: a cycle-indexed reference model predicts grants
// and output windows; a negedge monitor compares every cycle and pops expected grants.
module tb_morse_src_arbiter;
  localparam int unsigned N    = 3;
  localparam int unsigned HOLD = 4;
  localparam int unsigned GAP  = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [N-1:0] sym0 = '0;
  logic [N-1:0] sym1 = '0;
  logic         gnt0, gnt1, sel, out_valid, busy;
  logic [N-1:0] sym_out;

  always #5 clk = ~clk;

  morse_src_arbiter #(.N(N), .HOLD(HOLD), .GAP(GAP)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .sym0(sym0), .req1(req1), .sym1(sym1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .sym_out(sym_out),
    .out_valid(out_valid), .busy(busy)
  );

  typedef struct {
    bit           src;
    logic [N-1:0] sym;
    int unsigned  gedge;
  } grant_t;

  grant_t      exp_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  bit          checking = 0;

  // Reference model state: edge index of the latest grant, earliest edge for the next one.
  int unsigned  next_arb = 0;
  int unsigned  g = 0;
  bit           g_valid = 0;
  bit           last1 = 1;
  bit           win1 = 0;
  bit           exp_sel = 0;
  logic [N-1:0] exp_sym = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    grant_t t;
    cyc++;
    if (reset) begin
      next_arb = cyc + 1;
      last1    = 1;
      g_valid  = 0;
      exp_sel  = 0;
      exp_sym  = '0;
    end else if (cyc >= next_arb && (req0 || req1)) begin
      if (req0 && req1) win1 = !last1;
      else              win1 = req1;
      last1    = win1;
      g        = cyc;
      g_valid  = 1;
      exp_sel  = !win1;
      exp_sym  = win1 ? sym1 : sym0;
      next_arb = cyc + HOLD + GAP + 1;
      t.src    = win1;
      t.sym    = exp_sym;
      t.gedge  = cyc;
      exp_q.push_back(t);
    end
  end

  always @(negedge clk) begin
    bit     e_ov, e_busy, e_g0, e_g1;
    grant_t t;
    if (checking) begin
      e_ov   = g_valid && (cyc - g < HOLD);
      e_busy = g_valid && (cyc - g < HOLD + GAP);
      e_g0   = g_valid && (cyc == g) && !last1;
      e_g1   = g_valid && (cyc == g) && last1;
      chk("gnt0", {31'b0, gnt0}, {31'b0, e_g0});
      chk("gnt1", {31'b0, gnt1}, {31'b0, e_g1});
      chk("gnt_exclusive", {31'b0, gnt0 & gnt1}, 32'd0);
      chk("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
      chk("busy", {31'b0, busy}, {31'b0, e_busy});
      chk("sel", {31'b0, sel}, {31'b0, exp_sel});
      chk("sym_out", 32'(sym_out), 32'(exp_sym));
      if (gnt0 || gnt1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'd1, 32'd0);
        end else begin
          t = exp_q.pop_front();
          chk("grant_cycle", cyc, t.gedge);
          chk("grant_src", {31'b0, gnt1}, {31'b0, t.src});
          chk("grant_sym", 32'(sym_out), 32'(t.sym));
        end
      end else if (exp_q.size() != 0 && exp_q[0].gedge <= cyc) begin
        t = exp_q.pop_front();
        chk("missed_grant", 32'd0, 32'd1);
      end
    end
  end

  initial begin
    @(posedge clk);
    checking = 1;
  end

  task automatic step_drop();
    @(negedge clk);
    if (gnt0) req0 = 1'b0;
    if (gnt1) req1 = 1'b0;
  endtask

  task automatic wait_gnt(input bit which, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(which ? gnt1 : gnt0) && n < 20);
    if (!(which ? gnt1 : gnt0)) chk(nm, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single request from source 0
    req0 = 1'b1; sym0 = 3'b101;
    wait_gnt(0, "timeout_single");
    req0 = 1'b0;
    repeat (10) @(negedge clk);

    // Simultaneous requests, alternating service
    req0 = 1'b1; req1 = 1'b1; sym0 = 3'b001; sym1 = 3'b110;
    repeat (20) step_drop();

    // Source 1 held high while its symbol changes under HOLD
    req1 = 1'b1; sym1 = 3'b010;
    repeat (25) begin
      @(negedge clk);
      if (out_valid && !gnt1) sym1 = N'($urandom);
    end
    req1 = 1'b0;
    repeat (10) @(negedge clk);

    // Reset on the second HOLD cycle, then a tie must go to source 0
    req1 = 1'b1; sym1 = 3'b011;
    wait_gnt(1, "timeout_pre_reset");
    req1 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; sym0 = 3'b100; sym1 = 3'b111;
    repeat (20) step_drop();

    // One-cycle req0 pulse during GAP must be dropped
    req1 = 1'b1; sym1 = 3'b001;
    wait_gnt(1, "timeout_gap_setup");
    req1 = 1'b0;
    n = 0;
    while (out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    req0 = 1'b1; sym0 = 3'b111;
    @(negedge clk);
    req0 = 1'b0;
    repeat (12) @(negedge clk);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      else if ($urandom_range(199) == 0) reset = 1'b1;
      if (gnt0) begin
        if ($urandom_range(1) == 1) begin req0 = 1'b1; sym0 = N'($urandom); end
        else req0 = 1'b0;
      end else if (req0) begin
        if ($urandom_range(19) == 0) req0 = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        req0 = 1'b1; sym0 = N'($urandom);
      end else sym0 = N'($urandom);
      if (gnt1) begin
        if ($urandom_range(1) == 1) begin req1 = 1'b1; sym1 = N'($urandom); end
        else req1 = 1'b0;
      end else if (req1) begin
        if ($urandom_range(19) == 0) req1 = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        req1 = 1'b1; sym1 = N'($urandom);
      end else sym1 = N'($urandom);
    end

    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (12) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
